game_controller: RTL and testbench

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/snake_pkg.sv | 12 +
 rtl/bcd_counter2.sv | 31 +++
 rtl/game_controller.sv | 115 +++++++++++
 tb/tb_game_controller.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake game: FSM state encoding and BCD digit width.
package snake_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;
endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD up-counter that sticks at 99; clear wins over enable.
module bcd_counter2
  import snake_pkg::*;
(
  input  logic               VGA_clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               enable,
  output logic [2*BCD_W-1:0] bcd
);
  logic [BCD_W-1:0] ones, tens;

  always_ff @(posedge VGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      ones <= '0;
      tens <= '0;
    end else if (clear) begin
      ones <= '0;
      tens <= '0;
    end else if (enable && !(tens == BCD_NINE && ones == BCD_NINE)) begin
      if (ones == BCD_NINE) begin
        ones <= '0;
        tens <= tens + 1'b1;
      end else begin
        ones <= ones + 1'b1;
      end
    end
  end

  assign bcd = {tens, ones};
endmodule

// File: rtl/game_controller.sv
// Snake game sequencer: run/pause/over FSM, move pacing from frame ticks,
// growth, scoring and speed-up on apples.
module game_controller
  import snake_pkg::*;
#(
  parameter int FRAMES_INIT   = 8,
  parameter int FRAMES_MIN    = 2,
  parameter int SPEEDUP_EVERY = 4,
  parameter int MAX_SIZE      = 31
) (
  input  logic       VGA_clk,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       go,
  input  logic       pause,
  input  logic       lethal,
  input  logic       apple_hit,
  output logic       update,
  output logic       apple_respawn,
  output logic [4:0] size,
  output logic [7:0] score_bcd,
  output logic       game_over,
  output logic       win,
  output logic [1:0] state
);
  localparam int PW = (FRAMES_INIT < 2) ? 1 : $clog2(FRAMES_INIT + 1);
  localparam int SW = (SPEEDUP_EVERY < 2) ? 1 : $clog2(SPEEDUP_EVERY + 1);

  state_t         st;
  logic [PW-1:0]  period, frame_cnt;
  logic [SW-1:0]  speed_cnt;
  logic [4:0]     size_r;
  logic           update_r, respawn_r, win_r, over_r;

  logic play, eat, eat_win, leave, wrap, move, start_game;

  // Lethal dominates everything; the winning apple also ends the game.
  assign play       = (st == PLAY);
  assign eat        = play && apple_hit && !lethal;
  assign eat_win    = eat && (size_r == 5'(MAX_SIZE - 1));
  assign leave      = play && (lethal || eat_win || pause);
  assign wrap       = (frame_cnt >= period - 1'b1);
  assign move       = play && frame_tick && !leave && wrap;
  assign start_game = (st == IDLE || st == OVER) && go;

  always_ff @(posedge VGA_clk or negedge start) begin
    if (!start) begin
      st        <= IDLE;
      size_r    <= 5'd1;
      period    <= PW'(FRAMES_INIT);
      frame_cnt <= '0;
      speed_cnt <= '0;
      update_r  <= 1'b0;
      respawn_r <= 1'b0;
      win_r     <= 1'b0;
      over_r    <= 1'b0;
    end else begin
      update_r  <= move;
      respawn_r <= eat && !eat_win;
      case (st)
        IDLE, OVER: if (go) begin
          st        <= PLAY;
          over_r    <= 1'b0;
          win_r     <= 1'b0;
          size_r    <= 5'd1;
          period    <= PW'(FRAMES_INIT);
          frame_cnt <= '0;
          speed_cnt <= '0;
        end
        PLAY: begin
          if (lethal) begin
            st     <= OVER;
            over_r <= 1'b1;
            win_r  <= 1'b0;
          end else begin
            if (apple_hit) begin
              size_r <= size_r + 1'b1;
              if (speed_cnt == SW'(SPEEDUP_EVERY - 1)) begin
                speed_cnt <= '0;
                if (period > PW'(FRAMES_MIN)) period <= period - 1'b1;
              end else begin
                speed_cnt <= speed_cnt + 1'b1;
              end
            end
            if (eat_win) begin
              st     <= OVER;
              over_r <= 1'b1;
              win_r  <= 1'b1;
            end else if (pause) begin
              st <= PAUSE;
            end
            // Ticks landing on a departure from PLAY are dropped entirely.
            if (frame_tick && !leave) frame_cnt <= wrap ? '0 : frame_cnt + 1'b1;
          end
        end
        PAUSE: if (pause) st <= PLAY;
      endcase
    end
  end

  bcd_counter2 u_score (
    .VGA_clk (VGA_clk),
    .rst_n   (start),
    .clear   (start_game),
    .enable  (eat),
    .bcd     (score_bcd)
  );

  assign update        = update_r;
  assign apple_respawn = respawn_r;
  assign size          = size_r;
  assign game_over     = over_r;
  assign win           = win_r;
  assign state         = st;
endmodule

// File: tb/tb_game_controller.sv
// Directed vector table against two controller instances (default and MAX_SIZE=6).
module tb_game_controller;
  typedef logic [4:0] in_t; // {go, pause, lethal, apple_hit, frame_tick}
  localparam in_t I_NONE  = 5'b00000;
  localparam in_t I_TICK  = 5'b00001;
  localparam in_t I_APPLE = 5'b00010;
  localparam in_t I_LETH  = 5'b00100;
  localparam in_t I_PAUSE = 5'b01000;
  localparam in_t I_GO    = 5'b10000;

  typedef struct {
    logic       b;
    in_t        in;
    logic [1:0] st;
    logic       upd, resp;
    logic [4:0] size;
    logic [7:0] score;
    logic       gov, win;
  } vec_t;

  logic VGA_clk = 1'b0;
  logic start = 1'b0;
  in_t  in_a = '0, in_b = '0;

  logic       upd_a, resp_a, gov_a, win_a, upd_b, resp_b, gov_b, win_b;
  logic [4:0] size_a, size_b;
  logic [7:0] score_a, score_b;
  logic [1:0] st_a, st_b;

  int pass = 0, total = 0;
  vec_t tbl[$];

  always #5 VGA_clk = ~VGA_clk;

  game_controller dut_a (
    .VGA_clk(VGA_clk), .start(start),
    .frame_tick(in_a[0]), .go(in_a[4]), .pause(in_a[3]), .lethal(in_a[2]), .apple_hit(in_a[1]),
    .update(upd_a), .apple_respawn(resp_a), .size(size_a), .score_bcd(score_a),
    .game_over(gov_a), .win(win_a), .state(st_a)
  );

  game_controller #(.MAX_SIZE(6)) dut_b (
    .VGA_clk(VGA_clk), .start(start),
    .frame_tick(in_b[0]), .go(in_b[4]), .pause(in_b[3]), .lethal(in_b[2]), .apple_hit(in_b[1]),
    .update(upd_b), .apple_respawn(resp_b), .size(size_b), .score_bcd(score_b),
    .game_over(gov_b), .win(win_b), .state(st_b)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input logic b, input in_t in, input logic [1:0] st, input logic upd,
                     input logic resp, input logic [4:0] sz, input logic [7:0] sc,
                     input logic gov, input logic w);
    vec_t v;
    v.b = b; v.in = in; v.st = st; v.upd = upd; v.resp = resp;
    v.size = sz; v.score = sc; v.gov = gov; v.win = w;
    tbl.push_back(v);
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_state"}, st_a, 0);
    check({tag, "_update"}, upd_a, 0);
    check({tag, "_respawn"}, resp_a, 0);
    check({tag, "_size"}, size_a, 1);
    check({tag, "_score"}, score_a, 0);
    check({tag, "_over"}, gov_a, 0);
    check({tag, "_win"}, win_a, 0);
  endtask

  initial begin
    // Start game, first move after 8 ticks.
    add(0, I_GO, 1, 0, 0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 7; i++) add(0, I_TICK, 1, 0, 0, 1, 8'h00, 0, 0);
    add(0, I_TICK, 1, 1, 0, 1, 8'h00, 0, 0);
    add(0, I_NONE, 1, 0, 0, 1, 8'h00, 0, 0);
    // Four apples: growth, score, respawns, period drops to 7.
    add(0, I_APPLE, 1, 0, 1, 2, 8'h01, 0, 0);
    add(0, I_NONE,  1, 0, 0, 2, 8'h01, 0, 0);
    add(0, I_APPLE, 1, 0, 1, 3, 8'h02, 0, 0);
    add(0, I_APPLE, 1, 0, 1, 4, 8'h03, 0, 0);
    add(0, I_APPLE, 1, 0, 1, 5, 8'h04, 0, 0);
    add(0, I_NONE,  1, 0, 0, 5, 8'h04, 0, 0);
    for (int i = 0; i < 6; i++) add(0, I_TICK, 1, 0, 0, 5, 8'h04, 0, 0);
    add(0, I_TICK, 1, 1, 0, 5, 8'h04, 0, 0);
    add(0, I_NONE, 1, 0, 0, 5, 8'h04, 0, 0);
    // Counter to 3, pause through 20 ticks, resume: 4 more ticks to move.
    for (int i = 0; i < 3; i++) add(0, I_TICK, 1, 0, 0, 5, 8'h04, 0, 0);
    add(0, I_PAUSE, 2, 0, 0, 5, 8'h04, 0, 0);
    for (int i = 0; i < 20; i++) add(0, I_TICK, 2, 0, 0, 5, 8'h04, 0, 0);
    add(0, I_GO | I_LETH | I_APPLE, 2, 0, 0, 5, 8'h04, 0, 0);
    add(0, I_PAUSE, 1, 0, 0, 5, 8'h04, 0, 0);
    for (int i = 0; i < 3; i++) add(0, I_TICK, 1, 0, 0, 5, 8'h04, 0, 0);
    add(0, I_TICK, 1, 1, 0, 5, 8'h04, 0, 0);
    add(0, I_NONE, 1, 0, 0, 5, 8'h04, 0, 0);
    // lethal+apple together: lethal only.
    add(0, I_LETH | I_APPLE, 3, 0, 0, 5, 8'h04, 1, 0);
    add(0, I_TICK,  3, 0, 0, 5, 8'h04, 1, 0);
    add(0, I_PAUSE, 3, 0, 0, 5, 8'h04, 1, 0);
    add(0, I_GO,    1, 0, 0, 1, 8'h00, 0, 0);
    add(0, I_GO | I_LETH,    3, 0, 0, 1, 8'h00, 1, 0);
    add(0, I_GO,             1, 0, 0, 1, 8'h00, 0, 0);
    add(0, I_PAUSE | I_LETH, 3, 0, 0, 1, 8'h00, 1, 0);
    // Restart restores period 8; a tick coincident with pause makes no move.
    add(0, I_GO, 1, 0, 0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 7; i++) add(0, I_TICK, 1, 0, 0, 1, 8'h00, 0, 0);
    add(0, I_TICK | I_PAUSE, 2, 0, 0, 1, 8'h00, 0, 0);
    add(0, I_PAUSE, 1, 0, 0, 1, 8'h00, 0, 0);
    add(0, I_TICK,  1, 1, 0, 1, 8'h00, 0, 0);
    add(0, I_NONE,  1, 0, 0, 1, 8'h00, 0, 0);
    // MAX_SIZE=6 instance: 5th apple wins without a respawn.
    add(1, I_GO, 1, 0, 0, 1, 8'h00, 0, 0);
    for (int i = 1; i <= 4; i++) add(1, I_APPLE, 1, 0, 1, 5'(i + 1), 8'(i), 0, 0);
    add(1, I_APPLE, 3, 0, 0, 6, 8'h05, 1, 1);
    add(1, I_NONE,  3, 0, 0, 6, 8'h05, 1, 1);
    add(1, I_GO,    1, 0, 0, 1, 8'h00, 0, 0);

    repeat (2) @(negedge VGA_clk);
    check_idle_a("reset_a");
    check("reset_b_state", st_b, 0);
    check("reset_b_size", size_b, 1);
    start = 1'b1;
    @(negedge VGA_clk);
    check_idle_a("post_release");

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      in_a = v.b ? I_NONE : v.in;
      in_b = v.b ? v.in : I_NONE;
      @(negedge VGA_clk);
      check($sformatf("v%0d_state", i),   v.b ? st_b    : st_a,    v.st);
      check($sformatf("v%0d_update", i),  v.b ? upd_b   : upd_a,   v.upd);
      check($sformatf("v%0d_respawn", i), v.b ? resp_b  : resp_a,  v.resp);
      check($sformatf("v%0d_size", i),    v.b ? size_b  : size_a,  v.size);
      check($sformatf("v%0d_score", i),   v.b ? score_b : score_a, v.score);
      check($sformatf("v%0d_over", i),    v.b ? gov_b   : gov_a,   v.gov);
      check($sformatf("v%0d_win", i),     v.b ? win_b   : win_a,   v.win);
    end
    in_a = I_NONE;
    in_b = I_NONE;

    // Reset right as a period completes: the pending move must vanish.
    for (int i = 0; i < 7; i++) begin
      in_a = I_TICK;
      @(negedge VGA_clk);
    end
    in_a = I_TICK;
    @(posedge VGA_clk);
    #1;
    in_a = I_NONE;
    start = 1'b0;
    #1;
    check_idle_a("midgame_reset");
    @(negedge VGA_clk);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge VGA_clk);
      check_idle_a($sformatf("after_reset%0d", i));
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
